// File: rtl/vx_itr_retaddr_unit_pkg.sv
// Shared definitions for the interrupt return-address unit: FSM state
// encoding, CSR addresses of the return-address registers and a width helper.
package vx_itr_retaddr_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } itr_state_e;

  // Warp 0 has its own CSR. The other warps read through RAV, which is indexed by warp id.
  localparam logic [11:0] CSR_RAVW0 = 12'hBC0;
  localparam logic [11:0] CSR_RAV   = 12'hBC1;

  // Gives a width of at least one bit, so a single-warp build still has a legal warp-id field.
  function automatic int log2up(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/vx_itr_retaddr_table.sv
// Per-warp return-PC register file.
// Each warp has its own write enable. There is one registered read port and
// per-warp "captured, not yet consumed" tracking.
module vx_itr_retaddr_table
  import vx_itr_retaddr_unit_pkg::*;
#(
  parameter int WARP_CNT = 4,
  parameter int XLEN     = 32,
  parameter int WID_W    = log2up(WARP_CNT)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [WARP_CNT-1:0]      wr_en,
  input  logic [WARP_CNT*XLEN-1:0] wr_data,
  input  logic                     rd_valid,
  input  logic [WID_W-1:0]         rd_wid,
  output logic [XLEN-1:0]          rd_data,
  output logic                     rd_data_valid,
  input  logic                     consume_valid,
  input  logic [WID_W-1:0]         consume_wid,
  output logic [WARP_CNT-1:0]      entry_valid
);

  logic [XLEN-1:0]     table_q [WARP_CNT];
  logic [WARP_CNT-1:0] valid_q, valid_d;
  logic [XLEN-1:0]     rd_data_q;
  logic                rd_data_valid_q;

  // A capture sets the valid flag and a consume clears it.
  // If both hit the same warp in one cycle, the capture wins.
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < WARP_CNT; i++) begin
      if (wr_en[i]) begin
        valid_d[i] = 1'b1;
      end else if (consume_valid && (consume_wid == WID_W'(i))) begin
        valid_d[i] = 1'b0;
      end
    end
  end

  // Table writes and the read port share one edge.
  // The read therefore samples the pre-write contents (read-before-write).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < WARP_CNT; i++) begin
        table_q[i] <= '0;
      end
      valid_q         <= '0;
      rd_data_q       <= '0;
      rd_data_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < WARP_CNT; i++) begin
        if (wr_en[i]) begin
          table_q[i] <= wr_data[i*XLEN +: XLEN];
        end
      end
      valid_q         <= valid_d;
      rd_data_valid_q <= rd_valid;
      if (rd_valid) begin
        if ({{(32-WID_W){1'b0}}, rd_wid} < 32'(WARP_CNT)) begin
          rd_data_q <= table_q[rd_wid];
        end else begin
          rd_data_q <= '0;
        end
      end
    end
  end

  assign rd_data       = rd_data_q;
  assign rd_data_valid = rd_data_valid_q;
  assign entry_valid   = valid_q;

endmodule

// File: rtl/vx_itr_retaddr_unit.sv
// Interrupt-side return-address unit.
// It arms JAL overload for a set of warps and captures each warp's true
// return PC when its overloaded JAL commits. It pulses done once every armed
// warp has left the kernel.
module vx_itr_retaddr_unit
  import vx_itr_retaddr_unit_pkg::*;
#(
  parameter int WARP_CNT = 4,
  parameter int XLEN     = 32,
  parameter int WID_W    = log2up(WARP_CNT)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     arm_valid,
  input  logic [WARP_CNT-1:0]      arm_mask,
  output logic                     arm_ready,
  output logic [WARP_CNT-1:0]      overload_jal,
  input  logic [WARP_CNT-1:0]      hit_mask,
  input  logic [WARP_CNT*XLEN-1:0] hit_pc,
  input  logic                     rd_valid,
  input  logic [WID_W-1:0]         rd_wid,
  output logic [XLEN-1:0]          rd_data,
  output logic                     rd_data_valid,
  input  logic                     consume_valid,
  input  logic [WID_W-1:0]         consume_wid,
  output logic [WARP_CNT-1:0]      entry_valid,
  output logic                     done,
  output logic                     arm_err
);

  itr_state_e          state_q, state_d;
  logic [WARP_CNT-1:0] pending_q, pending_d;
  logic [WARP_CNT-1:0] capture;
  logic                arm_err_q, arm_err_d;

  // Next-state logic: sequences arm, then collect, then done.
  // The pending set doubles as the JALOL flags, so a warp stops being
  // overloaded on the same edge that captures its return PC.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    arm_err_d = arm_err_q;
    capture   = '0;
    case (state_q)
      IDLE: begin
        if (arm_valid && (arm_mask != '0)) begin
          state_d   = ARMED;
          pending_d = arm_mask;
        end
      end
      ARMED: begin
        capture   = hit_mask & pending_q;
        pending_d = pending_q & ~hit_mask;
        if (pending_d == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        pending_d = '0;
      end
    endcase
    if (arm_valid && (state_q != IDLE)) begin
      arm_err_d = 1'b1;
    end
    // Pending is empty outside ARMED. Any hit there, or any hit on a warp that
    // is not pending, is therefore spurious.
    if ((hit_mask & ~pending_q) != '0) begin
      arm_err_d = 1'b1;
    end
  end

  // State, pending flags and the sticky error register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      arm_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      arm_err_q <= arm_err_d;
    end
  end

  assign arm_ready    = (state_q == IDLE);
  assign overload_jal = pending_q;
  assign done         = (state_q == DONE);
  assign arm_err      = arm_err_q;

  vx_itr_retaddr_table #(
    .WARP_CNT (WARP_CNT),
    .XLEN     (XLEN),
    .WID_W    (WID_W)
  ) u_table (
    .clk           (clk),
    .reset_n       (reset_n),
    .wr_en         (capture),
    .wr_data       (hit_pc),
    .rd_valid      (rd_valid),
    .rd_wid        (rd_wid),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .consume_valid (consume_valid),
    .consume_wid   (consume_wid),
    .entry_valid   (entry_valid)
  );

endmodule

// File: tb/tb_vx_itr_retaddr_unit.sv
// Directed bench for the interrupt return-address unit.
// Read responses are checked by a monitor against a queue of expected values.
module tb_vx_itr_retaddr_unit;

  localparam int WARP_CNT = 4;
  localparam int XLEN     = 32;
  localparam int WID_W    = 2;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic                     arm_valid;
  logic [WARP_CNT-1:0]      arm_mask;
  logic                     arm_ready;
  logic [WARP_CNT-1:0]      overload_jal;
  logic [WARP_CNT-1:0]      hit_mask;
  logic [WARP_CNT*XLEN-1:0] hit_pc;
  logic                     rd_valid;
  logic [WID_W-1:0]         rd_wid;
  logic [XLEN-1:0]          rd_data;
  logic                     rd_data_valid;
  logic                     consume_valid;
  logic [WID_W-1:0]         consume_wid;
  logic [WARP_CNT-1:0]      entry_valid;
  logic                     done;
  logic                     arm_err;

  int checkCount = 0;
  int passCount  = 0;
  logic [XLEN-1:0] expectedReads [$];

  vx_itr_retaddr_unit #(
    .WARP_CNT (WARP_CNT),
    .XLEN     (XLEN),
    .WID_W    (WID_W)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .arm_valid     (arm_valid),
    .arm_mask      (arm_mask),
    .arm_ready     (arm_ready),
    .overload_jal  (overload_jal),
    .hit_mask      (hit_mask),
    .hit_pc        (hit_pc),
    .rd_valid      (rd_valid),
    .rd_wid        (rd_wid),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .consume_valid (consume_valid),
    .consume_wid   (consume_wid),
    .entry_valid   (entry_valid),
    .done          (done),
    .arm_err       (arm_err)
  );

  // Free-running clock with a 10 ns period.
  always #5 clk = ~clk;

  // Compares one value and reports a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setPc(input int w, input logic [XLEN-1:0] pc);
    hit_pc[w*XLEN +: XLEN] = pc;
  endtask

  // Drives one cycle of stimulus and queues the expected read response.
  // The task then returns all strobes to idle.
  task automatic applyStimulus(input logic armV, input logic [3:0] armM, input logic [3:0] hitM,
                               input logic rdV, input logic [1:0] rdW,
                               input logic consV, input logic [1:0] consW,
                               input logic [31:0] rdExp);
    arm_valid     = armV;
    arm_mask      = armM;
    hit_mask      = hitM;
    rd_valid      = rdV;
    rd_wid        = rdW;
    consume_valid = consV;
    consume_wid   = consW;
    if (rdV) expectedReads.push_back(rdExp);
    tick();
    arm_valid     = 1'b0;
    arm_mask      = '0;
    hit_mask      = '0;
    rd_valid      = 1'b0;
    rd_wid        = '0;
    consume_valid = 1'b0;
    consume_wid   = '0;
  endtask

  // Each read response is compared against the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rd_data_valid === 1'b1) begin
        if (expectedReads.size() == 0) begin
          checkCount++;
          $display("[TB] FAIL unexpectedRead: actual rd_data_valid=1 required=0 (data 0x%08h)", rd_data);
        end else begin
          checkOutput("readData", rd_data, expectedReads.pop_front());
        end
      end
    end
  end

  // Directed scenario sequence.
  initial begin
    reset_n       = 1'b0;
    arm_valid     = 1'b0;
    arm_mask      = '0;
    hit_mask      = '0;
    hit_pc        = '0;
    rd_valid      = 1'b0;
    rd_wid        = '0;
    consume_valid = 1'b0;
    consume_wid   = '0;
    tick();
    tick();
    checkOutput("rstOverload", 32'(overload_jal), 32'h0);
    checkOutput("rstEntry",    32'(entry_valid),  32'h0);
    checkOutput("rstDone",     32'(done),         32'h0);
    checkOutput("rstErr",      32'(arm_err),      32'h0);
    checkOutput("rstReady",    32'(arm_ready),    32'h1);
    checkOutput("rstRdValid",  32'(rd_data_valid), 32'h0);
    checkOutput("rstRdData",   rd_data,           32'h0);
    reset_n = 1'b1;
    tick();

    // Basic capture across all four warps.
    $display("[TB] basic capture");
    setPc(0, 32'h8000_0010);
    setPc(1, 32'h8000_0014);
    setPc(2, 32'h8000_0018);
    setPc(3, 32'h8000_001C);
    applyStimulus(1, 4'b1111, 4'b0000, 0, 0, 0, 0, 0);
    checkOutput("armOverload", 32'(overload_jal), 32'hF);
    checkOutput("armReady",    32'(arm_ready),    32'h0);
    applyStimulus(0, 0, 4'b0001, 0, 0, 0, 0, 0);
    checkOutput("hit0Overload", 32'(overload_jal), 32'hE);
    checkOutput("hit0Entry",    32'(entry_valid),  32'h1);
    checkOutput("hit0Done",     32'(done),         32'h0);
    applyStimulus(0, 0, 4'b0010, 0, 0, 0, 0, 0);
    checkOutput("hit1Overload", 32'(overload_jal), 32'hC);
    applyStimulus(0, 0, 4'b0100, 0, 0, 0, 0, 0);
    checkOutput("hit2Overload", 32'(overload_jal), 32'h8);
    checkOutput("hit2Done",     32'(done),         32'h0);
    applyStimulus(0, 0, 4'b1000, 0, 0, 0, 0, 0);
    checkOutput("hit3Overload", 32'(overload_jal), 32'h0);
    checkOutput("hit3Entry",    32'(entry_valid),  32'hF);
    checkOutput("doneFull",     32'(done),         32'h1);
    checkOutput("doneReady",    32'(arm_ready),    32'h0);
    tick();
    checkOutput("doneDropped",  32'(done),         32'h0);
    checkOutput("idleReady",    32'(arm_ready),    32'h1);
    checkOutput("noErrBasic",   32'(arm_err),      32'h0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 32'h8000_0010);
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 32'h8000_0014);
    applyStimulus(0, 0, 0, 1, 2, 0, 0, 32'h8000_0018);
    applyStimulus(0, 0, 0, 1, 3, 0, 0, 32'h8000_001C);
    for (int w = 0; w < WARP_CNT; w++) begin
      applyStimulus(0, 0, 0, 0, 0, 1, 2'(w), 0);
    end
    checkOutput("allConsumed", 32'(entry_valid), 32'h0);

    // Two warps hit in the same cycle.
    $display("[TB] simultaneous hits");
    setPc(1, 32'h100);
    setPc(2, 32'h200);
    applyStimulus(1, 4'b0110, 0, 0, 0, 0, 0, 0);
    checkOutput("arm2Overload", 32'(overload_jal), 32'h6);
    applyStimulus(0, 0, 4'b0110, 0, 0, 0, 0, 0);
    checkOutput("simDone",      32'(done),         32'h1);
    checkOutput("simEntry",     32'(entry_valid),  32'h6);
    checkOutput("simOverload",  32'(overload_jal), 32'h0);
    tick();
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 32'h100);
    applyStimulus(0, 0, 0, 1, 2, 0, 0, 32'h200);
    checkOutput("noErrSim", 32'(arm_err), 32'h0);

    // A hit on an unarmed warp and a re-arm while ARMED are both errors.
    $display("[TB] spurious events");
    setPc(2, 32'hDEAD_BEEF);
    applyStimulus(1, 4'b0001, 0, 0, 0, 0, 0, 0);
    checkOutput("arm3Overload", 32'(overload_jal), 32'h1);
    applyStimulus(0, 0, 4'b0100, 0, 0, 0, 0, 0);
    checkOutput("spurErr",      32'(arm_err),      32'h1);
    checkOutput("spurEntry",    32'(entry_valid),  32'h6);
    checkOutput("spurOverload", 32'(overload_jal), 32'h1);
    applyStimulus(1, 4'b1111, 0, 0, 0, 0, 0, 0);
    checkOutput("rearmOverload", 32'(overload_jal), 32'h1);
    applyStimulus(0, 0, 0, 1, 2, 0, 0, 32'h200);
    setPc(0, 32'h44);
    applyStimulus(0, 0, 4'b0001, 0, 0, 0, 0, 0);
    checkOutput("spurDone",  32'(done),        32'h1);
    checkOutput("spurEntry2", 32'(entry_valid), 32'h7);
    tick();
    setPc(0, 32'h99);
    applyStimulus(0, 0, 4'b0001, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 32'h44);
    checkOutput("errSticky", 32'(arm_err), 32'h1);

    // Read/capture and consume/capture races on warp 1.
    $display("[TB] read and consume races");
    setPc(1, 32'hABC);
    applyStimulus(1, 4'b0010, 0, 0, 0, 0, 0, 0);
    checkOutput("arm4Overload", 32'(overload_jal), 32'h2);
    applyStimulus(0, 0, 4'b0010, 1, 1, 0, 0, 32'h100);
    checkOutput("raceDone", 32'(done), 32'h1);
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 32'hABC);
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 0);
    checkOutput("consumeEntry", 32'(entry_valid), 32'h5);
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 32'hABC);
    setPc(1, 32'hDEF);
    applyStimulus(1, 4'b0010, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 4'b0010, 0, 0, 1, 1, 0);
    checkOutput("captureWins", 32'(entry_valid), 32'h7);
    tick();
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 32'hDEF);

    // Reset while ARMED clears everything on that edge.
    $display("[TB] reset mid-operation");
    setPc(0, 32'h55);
    applyStimulus(1, 4'b1111, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 4'b0001, 0, 0, 0, 0, 0);
    checkOutput("preRstOverload", 32'(overload_jal), 32'hE);
    reset_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("midRstOverload", 32'(overload_jal), 32'h0);
    checkOutput("midRstEntry",    32'(entry_valid),  32'h0);
    checkOutput("midRstDone",     32'(done),         32'h0);
    checkOutput("midRstErr",      32'(arm_err),      32'h0);
    checkOutput("midRstReady",    32'(arm_ready),    32'h1);
    checkOutput("midRstRdData",   rd_data,           32'h0);
    reset_n = 1'b1;
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 32'h0);
    tick();
    tick();
    checkOutput("readQueueDrained", 32'(expectedReads.size()), 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
